// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request to the instruction memory,
// holds each returned word for decode, handles redirects and stale responses.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid/target         taken branch/jump, absolute target (low bits ignored)
//   imem_req/addr/gnt             request channel (handshake on req && gnt)
//   imem_rvalid/rdata             response channel (only observed while waiting)
//   instr_valid/instr/instr_pc    instruction to decode (handshake on valid && ready)
//   instr_ready                   decode accepts held instruction
module fetch_ctrl #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                instr_ready
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic [31:0]           instr_q, instr_d;
    logic [PC_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic [PC_WIDTH-1:0]   target_aligned;

    // Redirect targets are word aligned; low two bits are discarded.
    assign target_aligned = redirect_target & ~PC_WIDTH'(3);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Next-state logic; redirect always wins over grant/response/ready.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = target_aligned;
                    // A grant for the old address is already in flight: its
                    // response must be swallowed before fetching the new PC.
                    if (imem_gnt) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = target_aligned;
                    if (imem_rvalid) begin
                        // Response consumed this cycle; nothing left to drop.
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d    = S_HOLD;
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target_aligned;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + PC_WIDTH'(4);
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Handshake outputs are suppressed while reset is applied.
    assign imem_req    = (state_q == S_REQ)  && !rst;
    assign instr_valid = (state_q == S_HOLD) && !rst;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of all PC/address signals.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken, load redirect_target.
REQ-006 SHALL have port redirect_target  input  PC_WIDTH  absolute target PC.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-008 SHALL have port imem_addr  output  PC_WIDTH  request address, equal to current fetch PC.
REQ-009 SHALL have port imem_gnt  input  1  memory accepts request this cycle (req && gnt = handshake).
REQ-010 SHALL have port imem_rvalid  input  1  response data valid.
REQ-011 SHALL have port imem_rdata  input  32  response instruction word.
REQ-012 SHALL have port instr_valid  output  1  instruction presented to decode.
REQ-013 SHALL have port instr  output  32  instruction word.
REQ-014 SHALL have port instr_pc  output  PC_WIDTH  PC of presented instruction.
REQ-015 SHALL have port instr_ready  input  1  decode consumes instruction (valid && ready = handshake).

Function
REQ-016 SHALL implement FSM states REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-017 REQ: imem_req=1; on imem_gnt -> WAIT; imem_addr SHALL stay stable until gnt.
REQ-018 WAIT: imem_req=0; on imem_rvalid capture imem_rdata into instr and fetch PC into instr_pc, -> HOLD.
REQ-019 HOLD: instr_valid=1, instr/instr_pc stable; on instr_ready fetch PC <= fetch PC + 4 (mod 2^PC_WIDTH, wraps silently), -> REQ next cycle.
REQ-020 Fetch latency SHALL be: gnt cycle, then rvalid cycle N, instr_valid first high at cycle N+1.
REQ-021 redirect_valid in REQ: fetch PC <= {redirect_target[PC_WIDTH-1:2],2'b00}; stay REQ; request not granted in that same cycle is re-issued to new address; a same-cycle gnt is treated as stale (see REQ-022).
REQ-022 redirect_valid in WAIT (or REQ with simultaneous gnt): load new PC, set drop flag; next response SHALL be discarded (no instr_valid), then -> REQ with new PC.
REQ-023 rvalid in same cycle as redirect in WAIT SHALL be discarded, -> REQ immediately, no drop flag.
REQ-024 redirect_valid in HOLD: instr_valid SHALL drop next cycle, held instruction discarded regardless of instr_ready, fetch PC <= target, -> REQ.
REQ-025 Redirect SHALL take priority over instr_ready and over the +4 increment.
REQ-026 Redirect target low two bits SHALL be forced to 0.
REQ-027 imem_rvalid while not in WAIT SHALL be ignored.
REQ-028 instr_valid SHALL never be 1 outside HOLD; never asserted for a dropped response.

Reset
REQ-029 While rst=1: state <= REQ, fetch PC <= RESET_PC, drop flag <= 0, instr <= 0, instr_pc <= 0.
REQ-030 While rst=1 outputs SHALL be imem_req=0, instr_valid=0; imem_req rises first cycle after rst deasserts, imem_addr=RESET_PC.
REQ-031 rst mid-transaction SHALL abandon outstanding request; responses arriving after reset with no new gnt SHALL be ignored.

Verification
REQ-032 Reset, gnt and rvalid 1 cycle after req, instr_ready=1 -> addresses 0x0,0x4,0x8 issued, instr_pc matches each, one instruction per 3 cycles.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, no new fetch; ready=1 -> next addr +4.
REQ-034 Redirect to 0x103 while in WAIT at PC 0x8 -> response for 0x8 dropped, next imem_addr=0x100, instr_pc=0x100.
REQ-035 Redirect to 0x40 in HOLD same cycle as instr_ready -> held instr discarded, next imem_addr=0x40.
REQ-036 Fetch PC 0xFFFFFFFC accepted -> next imem_addr=0x0 (wrap).
REQ-037 rst asserted in WAIT, stale rvalid after release -> ignored, imem_addr=RESET_PC, instr_valid=0 until real response.
